// File: rtl/starflux_pkg.sv
// starflux_pkg: screen geometry, colours, FSM states and bullet slot layout
// shared by the game-state and display blocks. Rev 1.0
`default_nettype none

package starflux_pkg;

  localparam int         SCREEN_W = 160;
  localparam int         SCREEN_H = 120;
  localparam logic [6:0] USER_Y   = 7'd0;
  localparam logic [6:0] ENEMY_Y  = 7'd119;

  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] BLUE  = 3'b001;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic       live;
    logic       dir;
    logic [7:0] x;
    logic [6:0] y;
  } slot_t;

  function automatic logic [7:0] absdiff8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bullet_engine_slot_alloc.sv
// slot_alloc: finds the lowest and second-lowest free slot in the live vector. Rev 1.0
`default_nettype none

module slot_alloc #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_live,
  output logic [W-1:0] o_first,
  output logic [W-1:0] o_second,
  output logic         o_any_free,
  output logic         o_two_free
);

  always_comb begin
    o_first    = '0;
    o_second   = '0;
    o_any_free = 1'b0;
    o_two_free = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!i_live[i]) begin
        if (!o_any_free) begin
          o_first    = W'(i);
          o_any_free = 1'b1;
        end else if (!o_two_free) begin
          o_second   = W'(i);
          o_two_free = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bullet_engine.sv
// bullet_engine: bullet pool with fire-handshake spawn, per-frame sweep and enemy hit detection.
// Optional enemy bullets enabled by defining ENEMY_FIRE_EN. Rev 1.0
`default_nettype none

module bullet_engine
  import starflux_pkg::*;
#(
  parameter int N_BULLETS = 8,
  parameter int SPEED     = 1,
  parameter int HITBOX    = 4,
  parameter int IW        = $clog2(N_BULLETS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_frame_tick,
  input  logic          i_fire,
  output logic          o_fire_ready,
  input  logic [7:0]    i_user_x,
  input  logic [7:0]    i_enemy_x,
  input  logic [IW-1:0] i_rd_idx,
  output logic [7:0]    o_rd_x,
  output logic [6:0]    o_rd_y,
  output logic          o_rd_valid,
  output logic          o_busy,
  output logic          o_hit,
  output logic [7:0]    o_hit_count,
  input  logic          i_enemy_fire,
  output logic          o_enemy_fire_ready,
  output logic          o_user_hit
);

  localparam logic [IW-1:0] c_LAST = IW'(N_BULLETS - 1);

  state_t           r_state, w_state_nxt;
  logic [IW-1:0]    r_idx;
  slot_t            r_slots [N_BULLETS];
  logic             r_hit, r_user_hit;
  logic [7:0]       r_hit_count;
  logic [7:0]       r_rd_x;
  logic [6:0]       r_rd_y;
  logic             r_rd_valid;

  logic [N_BULLETS-1:0] w_live;
  logic [IW-1:0]        w_first, w_second;
  logic                 w_any_free, w_two_free;
  logic                 w_idle, w_fire_acc;
  slot_t                w_cur;
  logic [7:0]           w_ny_up;
  logic                 w_free_up, w_near_enemy, w_down;

  always_comb begin
    for (int i = 0; i < N_BULLETS; i++) w_live[i] = r_slots[i].live;
  end

  slot_alloc #(.N(N_BULLETS), .W(IW)) u_alloc (
    .i_live     (w_live),
    .o_first    (w_first),
    .o_second   (w_second),
    .o_any_free (w_any_free),
    .o_two_free (w_two_free)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_frame_tick) w_state_nxt = ST_UPDATE;
      ST_UPDATE: if (r_idx == c_LAST) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_idle       = (r_state == ST_IDLE);
  assign w_fire_acc   = i_fire && o_fire_ready;
  assign o_fire_ready = w_idle && w_any_free;

  // Sweep datapath: one slot per UPDATE cycle; y+SPEED kept 8 bits so it cannot wrap.
  assign w_cur        = r_slots[r_idx];
  assign w_ny_up      = {1'b0, w_cur.y} + 8'(SPEED);
  assign w_free_up    = (w_ny_up >= {1'b0, ENEMY_Y});
  assign w_near_enemy = (absdiff8(w_cur.x, i_enemy_x) <= 8'(HITBOX));

`ifdef ENEMY_FIRE_EN
  logic          w_efire_acc, w_free_dn, w_near_user;
  logic [IW-1:0] w_eslot;
  // With a simultaneous user fire the enemy needs the second free slot.
  assign o_enemy_fire_ready = w_idle && (i_fire ? w_two_free : w_any_free);
  assign w_efire_acc        = i_enemy_fire && o_enemy_fire_ready;
  assign w_eslot            = w_fire_acc ? w_second : w_first;
  assign w_down             = (w_cur.dir == DIR_DOWN);
  assign w_free_dn          = (w_cur.y < 7'(SPEED + 1));
  assign w_near_user        = (absdiff8(w_cur.x, i_user_x) <= 8'(HITBOX));
`else
  logic w_unused;
  assign o_enemy_fire_ready = 1'b0;
  assign w_down             = 1'b0;
  assign w_unused           = ^{i_enemy_fire, w_second, w_two_free};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_hit       <= 1'b0;
      r_user_hit  <= 1'b0;
      r_hit_count <= '0;
      r_rd_x      <= '0;
      r_rd_y      <= '0;
      r_rd_valid  <= 1'b0;
      for (int i = 0; i < N_BULLETS; i++) r_slots[i] <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hit      <= 1'b0;
      r_user_hit <= 1'b0;
      r_rd_x     <= r_slots[i_rd_idx].x;
      r_rd_y     <= r_slots[i_rd_idx].y;
      r_rd_valid <= r_slots[i_rd_idx].live;
      r_idx      <= (r_state == ST_UPDATE) ? r_idx + IW'(1) : '0;

      if (w_fire_acc)
        r_slots[w_first] <= '{live: 1'b1, dir: DIR_UP, x: i_user_x, y: USER_Y + 7'd1};
`ifdef ENEMY_FIRE_EN
      if (w_efire_acc)
        r_slots[w_eslot] <= '{live: 1'b1, dir: DIR_DOWN, x: i_enemy_x, y: ENEMY_Y - 7'd1};
`endif

      if (r_state == ST_UPDATE && w_cur.live) begin
        if (!w_down) begin
          if (w_free_up) begin
            r_slots[r_idx].live <= 1'b0;
            if (w_near_enemy) begin
              r_hit <= 1'b1;
              if (r_hit_count != 8'hFF) r_hit_count <= r_hit_count + 8'd1;
            end
          end else begin
            r_slots[r_idx].y <= w_ny_up[6:0];
          end
        end
`ifdef ENEMY_FIRE_EN
        else begin
          if (w_free_dn) begin
            r_slots[r_idx].live <= 1'b0;
            if (w_near_user) r_user_hit <= 1'b1;
          end else begin
            r_slots[r_idx].y <= w_cur.y - 7'(SPEED);
          end
        end
`endif
      end
    end
  end

  assign o_busy      = !w_idle;
  assign o_hit       = r_hit;
  assign o_user_hit  = r_user_hit;
  assign o_hit_count = r_hit_count;
  assign o_rd_x      = r_rd_x;
  assign o_rd_y      = r_rd_y;
  assign o_rd_valid  = r_rd_valid;

endmodule

`default_nettype wire

// File: tb/tb_bullet_engine.sv
// tb_bullet_engine: frame-level reference model plus directed scenarios for bullet_engine.
`default_nettype none

module tb_bullet_engine;

  localparam int N      = 8;
  localparam int SPEED  = 1;
  localparam int HITBOX = 4;
`ifdef ENEMY_FIRE_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       frame_tick = 1'b0, fire = 1'b0, efire = 1'b0;
  logic [7:0] user_x = 8'd0, enemy_x = 8'd0;
  logic [2:0] rd_idx = 3'd0;
  logic       fire_ready, rd_valid, busy, hit, efire_ready, user_hit;
  logic [7:0] rd_x, hit_count;
  logic [6:0] rd_y;

  always #5 clk = ~clk;

  bullet_engine #(.N_BULLETS(N), .SPEED(SPEED), .HITBOX(HITBOX)) dut (
    .clk(clk), .rst_n(rst_n), .i_frame_tick(frame_tick), .i_fire(fire),
    .o_fire_ready(fire_ready), .i_user_x(user_x), .i_enemy_x(enemy_x),
    .i_rd_idx(rd_idx), .o_rd_x(rd_x), .o_rd_y(rd_y), .o_rd_valid(rd_valid),
    .o_busy(busy), .o_hit(hit), .o_hit_count(hit_count),
    .i_enemy_fire(efire), .o_enemy_fire_ready(efire_ready), .o_user_hit(user_hit)
  );

  int checks = 0, errors = 0;
  int hit_pulses = 0, uhit_pulses = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Reference model: a whole frame is applied at once when the tick is taken;
  // the hit pulses are then replayed one slot per cycle.
  bit m_live [N];
  bit m_down [N];
  int m_x    [N];
  int m_y    [N];
  bit m_hitv [N];
  bit m_uhitv[N];
  int m_hits = 0, m_busy_left = 0;
  bit e_valid = 1'b0;
  int e_x = 0, e_y = 0;

  function automatic int m_nfree();
    int n = 0;
    for (int i = 0; i < N; i++) if (!m_live[i]) n++;
    return n;
  endfunction

  function automatic int m_lowest_free();
    for (int i = 0; i < N; i++) if (!m_live[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int k;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_live[i] = 0; m_down[i] = 0; m_x[i] = 0; m_y[i] = 0; m_hitv[i] = 0; m_uhitv[i] = 0;
      end
      m_hits = 0; m_busy_left = 0; e_valid = 0; e_x = 0; e_y = 0;
    end else begin
      e_valid = m_live[rd_idx]; e_x = m_x[rd_idx]; e_y = m_y[rd_idx];
      if (m_busy_left == 0) begin
        if (fire) begin
          k = m_lowest_free();
          if (k >= 0) begin m_live[k] = 1; m_down[k] = 0; m_x[k] = user_x; m_y[k] = 1; end
        end
        if (EN && efire) begin
          k = m_lowest_free();
          if (k >= 0) begin m_live[k] = 1; m_down[k] = 1; m_x[k] = enemy_x; m_y[k] = 118; end
        end
        if (frame_tick) begin
          for (int i = 0; i < N; i++) begin
            m_hitv[i] = 0; m_uhitv[i] = 0;
            if (m_live[i] && !m_down[i]) begin
              if (m_y[i] + SPEED >= 119) begin
                m_live[i] = 0;
                if (absd(m_x[i], enemy_x) <= HITBOX) begin
                  m_hitv[i] = 1;
                  if (m_hits < 255) m_hits++;
                end
              end else m_y[i] = m_y[i] + SPEED;
            end else if (m_live[i]) begin
              if (m_y[i] - SPEED <= 0) begin
                m_live[i] = 0;
                m_uhitv[i] = (absd(m_x[i], user_x) <= HITBOX);
              end else m_y[i] = m_y[i] - SPEED;
            end
          end
          m_busy_left = N + 1;
        end
      end else m_busy_left--;
    end
  end

  always @(negedge clk) begin
    int b;
    bit idle, eh, euh, eefr;
    b    = m_busy_left;
    idle = (b == 0);
    eh   = (b >= 1 && b <= N) ? m_hitv[N - b]  : 1'b0;
    euh  = (b >= 1 && b <= N) ? m_uhitv[N - b] : 1'b0;
    eefr = EN && idle && (fire ? (m_nfree() >= 2) : (m_nfree() >= 1));
    chk("busy", int'(busy), int'(!idle));
    chk("hit", int'(hit), int'(eh));
    chk("user_hit", int'(user_hit), int'(EN && euh));
    chk("fire_ready", int'(fire_ready), int'(idle && m_nfree() > 0));
    chk("enemy_fire_ready", int'(efire_ready), int'(eefr));
    if (idle) begin
      chk("rd_valid", int'(rd_valid), int'(e_valid));
      chk("hit_count", int'(hit_count), m_hits);
      if (e_valid) begin
        chk("rd_x", int'(rd_x), e_x);
        chk("rd_y", int'(rd_y), e_y);
      end
    end
    if (hit) hit_pulses++;
    if (user_hit) uhit_pulses++;
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fire = 0; efire = 0; frame_tick = 0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic fire_once(input int x);
    user_x = 8'(x); fire = 1'b1; step(1); fire = 1'b0;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      frame_tick = 1'b1; step(1); frame_tick = 1'b0; step(N + 1);
    end
  endtask

  task automatic read_slot(input int idx, input string name, input int v, input int x, input int y);
    rd_idx = 3'(idx); step(1);
    chk({name, "_valid"}, int'(rd_valid), v);
    if (v != 0) begin
      chk({name, "_x"}, int'(rd_x), x);
      chk({name, "_y"}, int'(rd_y), y);
    end
  endtask

  initial begin
    int bw, cyc;
    // Reset values
    rst_n = 1'b0; step(2);
    chk("rst_fire_ready", int'(fire_ready), 1);
    chk("rst_rd_x", int'(rd_x), 0);
    chk("rst_rd_y", int'(rd_y), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_hit_count", int'(hit_count), 0);
    chk("rst_efire_ready", int'(efire_ready), int'(EN));
    rst_n = 1'b1; step(1);

    // Reset in the middle of a sweep
    enemy_x = 8'd150;
    fire_once(7); fire_once(9);
    frame_tick = 1'b1; step(1); frame_tick = 1'b0; step(3);
    rst_n = 1'b0; #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_hit_count", int'(hit_count), 0);
    chk("midrst_fire_ready", int'(fire_ready), 1);
    chk("midrst_rd_valid", int'(rd_valid), 0);
    step(1); rst_n = 1'b1; step(1);
    for (int i = 0; i < N; i++) read_slot(i, "midrst_slot", 0, 0, 0);

    // Single spawn and flight
    fire_once(40);
    read_slot(0, "spawn", 1, 40, 1);
    tick(3);
    read_slot(0, "fly3", 1, 40, 4);

    // Fill pool, refuse a ninth fire, reuse slot 3 after it flies out
    do_reset();
    fire_once(10); fire_once(11); fire_once(12);
    tick(60);
    fire_once(13);
    tick(58);
    read_slot(0, "aged_out0", 0, 0, 0);
    read_slot(3, "young3", 1, 13, 59);
    user_x = 8'd20; fire = 1'b1; step(7); fire = 1'b0;
    chk("full_fire_ready", int'(fire_ready), 0);
    fire_once(99);
    read_slot(7, "slot7", 1, 20, 1);
    read_slot(3, "slot3_kept", 1, 13, 59);
    tick(60);
    chk("slot3_freed_ready", int'(fire_ready), 1);
    fire_once(77);
    read_slot(3, "reuse3", 1, 77, 1);

    // Hit inside the hitbox, then a near miss
    do_reset();
    enemy_x = 8'd83; hit_pulses = 0;
    fire_once(80);
    tick(117);
    chk("pre_hit_pulses", hit_pulses, 0);
    read_slot(0, "pre_hit", 1, 80, 118);
    tick(1);
    chk("hit_pulses", hit_pulses, 1);
    chk("hit_count_1", int'(hit_count), 1);
    read_slot(0, "hit_freed", 0, 0, 0);
    enemy_x = 8'd85;
    fire_once(80);
    tick(118);
    chk("miss_pulses", hit_pulses, 1);
    chk("miss_hit_count", int'(hit_count), 1);
    read_slot(0, "miss_freed", 0, 0, 0);

    // Tick held through a sweep is dropped
    do_reset();
    fire_once(5);
    bw = 0; frame_tick = 1'b1;
    repeat (N + 2) begin step(1); if (busy) bw++; end
    frame_tick = 1'b0;
    step(N + 1);
    chk("busy_width", bw, N + 1);
    read_slot(0, "single_advance", 1, 5, 2);

    // Enemy fire gating
    do_reset();
`ifdef ENEMY_FIRE_EN
    user_x = 8'd30; fire = 1'b1; step(7);
    enemy_x = 8'd90; efire = 1'b1; #1;
    chk("race_efire_ready", int'(efire_ready), 0);
    chk("race_fire_ready", int'(fire_ready), 1);
    step(1); fire = 1'b0; efire = 1'b0;
    chk("race_efire_ready_after", int'(efire_ready), 0);
    read_slot(7, "race_user", 1, 30, 1);
    do_reset();
    user_x = 8'd50; enemy_x = 8'd50; uhit_pulses = 0;
    efire = 1'b1; step(1); efire = 1'b0;
    read_slot(0, "enemy_spawn", 1, 50, 118);
    tick(117);
    read_slot(0, "enemy_low", 1, 50, 1);
    chk("pre_user_hit", uhit_pulses, 0);
    tick(1);
    chk("user_hit_pulses", uhit_pulses, 1);
    read_slot(0, "enemy_freed", 0, 0, 0);
`else
    efire = 1'b1; step(1); efire = 1'b0;
    chk("efire_ready_off", int'(efire_ready), 0);
    read_slot(0, "efire_ignored", 0, 0, 0);
`endif

    // Saturation of the hit counter
    do_reset();
    user_x = 8'd60; enemy_x = 8'd60; hit_pulses = 0;
    fire = 1'b1; frame_tick = 1'b1; cyc = 0;
    while (hit_pulses < 300 && cyc < 60000) begin step(1); cyc++; end
    fire = 1'b0; frame_tick = 1'b0;
    step(N + 2);
    chk("sat_reached_300", int'(hit_pulses >= 300), 1);
    chk("sat_hit_count", int'(hit_count), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
